trig_wheel_gen: RTL and testbench

Synthesizable missing-tooth trigger wheel generator: emits a crank-style tooth train (N-minus-M pattern) on a single-bit output at a programmable tooth period, for closed-loop bench and hardware-in-the-loop testing of the input-side sync decoder. It sits in the common/input area. Its `wheel_out` drives the decoder's `vrin` directly, through a mux selecting real sensor or simulated wheel. Configuration is latched once per revolution so the pattern is never torn mid-revolution.

---
 rtl/trig_wheel_gen.sv | 198 +++++++++++++++++++
 tb/tb_trig_wheel_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_wheel_gen.sv
// trig_wheel_gen
//   Missing-tooth (N-minus-M) crank wheel simulator. It produces a tooth train
//   on wheel_out that can stand in for a real VR/Hall sensor at the sync
//   decoder input. The period and tooth configuration are captured into shadow
//   registers only when leaving IDLE and at each revolution boundary, so a
//   revolution always finishes with the settings it started with.
//
// Ports
//   clk                    system clock
//   reset_n                asynchronous active-low reset
//   enable                 level; high runs the generator, low forces IDLE
//   tooth_period[31:0]     clocks per tooth pitch P (valid P >= 2)
//   trigger_tooth_cnt[7:0] tooth positions N, including the missing ones
//   trigger_teeth_missing[7:0] missing teeth M (valid 1 <= M < N)
//   wheel_out              generated tooth signal (registered)
//   tooth_num[7:0]         index of the most recently started present tooth
//   rev_pulse              one-cycle strobe with the rising edge of tooth 0
//   running                high while a tooth train is being generated
//   cfg_err                high while enabled with an invalid configuration
//
// Output handshake: there is none. Outputs are free-running registered
// levels/strobes, and all of them change only on clk.
module trig_wheel_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] tooth_period,
  input  logic [7:0]  trigger_tooth_cnt,
  input  logic [7:0]  trigger_teeth_missing,
  output logic        wheel_out,
  output logic [7:0]  tooth_num,
  output logic        rev_pulse,
  output logic        running,
  output logic        cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // phase down-counter, expires at 0
  logic [31:0] p_s_q, p_s_d;       // shadow period
  logic [7:0]  n_s_q, n_s_d;       // shadow tooth count
  logic [7:0]  m_s_q, m_s_d;       // shadow missing count
  logic [7:0]  miss_q, miss_d;     // remaining missing sub-periods in GAP
  logic [7:0]  tooth_d;
  logic        wheel_d, rev_d, run_d, err_d;

  logic        in_valid;
  logic [31:0] in_high_m1;         // H-1 computed from the live inputs
  logic [31:0] s_high_m1;          // H-1 from the shadow period
  logic [31:0] s_low_m1;           // L-1 from the shadow period
  logic [31:0] s_per_m1;           // P-1 from the shadow period
  logic [7:0]  last_tooth;         // index of the last present tooth

  assign in_valid   = (tooth_period >= 32'd2) &&
                      (trigger_teeth_missing != 8'd0) &&
                      (trigger_teeth_missing < trigger_tooth_cnt);
  assign in_high_m1 = (tooth_period >> 1) - 32'd1;
  assign s_high_m1  = (p_s_q >> 1) - 32'd1;
  assign s_low_m1   = p_s_q - (p_s_q >> 1) - 32'd1;
  assign s_per_m1   = p_s_q - 32'd1;
  // Shadow config is always valid (M < N), so this cannot underflow.
  assign last_tooth = n_s_q - m_s_q - 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_s_q     <= '0;
      n_s_q     <= '0;
      m_s_q     <= '0;
      miss_q    <= '0;
      tooth_num <= '0;
      wheel_out <= 1'b0;
      rev_pulse <= 1'b0;
      running   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_s_q     <= p_s_d;
      n_s_q     <= n_s_d;
      m_s_q     <= m_s_d;
      miss_q    <= miss_d;
      tooth_num <= tooth_d;
      wheel_out <= wheel_d;
      rev_pulse <= rev_d;
      running   <= run_d;
      cfg_err   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_s_d   = p_s_q;
    n_s_d   = n_s_q;
    m_s_d   = m_s_q;
    miss_d  = miss_q;
    tooth_d = tooth_num;
    wheel_d = 1'b0;
    rev_d   = 1'b0;
    run_d   = 1'b0;
    err_d   = 1'b0;

    if (!enable) begin
      // Disable has priority over everything, including a revolution boundary.
      // tooth_num keeps its last value.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            p_s_d   = tooth_period;
            n_s_d   = trigger_tooth_cnt;
            m_s_d   = trigger_teeth_missing;
            tooth_d = 8'd0;
            rev_d   = 1'b1;
            wheel_d = 1'b1;
            run_d   = 1'b1;
            cnt_d   = in_high_m1;
            state_d = S_HIGH;
          end else begin
            err_d = 1'b1;
          end
        end

        S_HIGH: begin
          run_d = 1'b1;
          if (cnt_q == 32'd0) begin
            cnt_d   = s_low_m1;
            state_d = S_LOW;
          end else begin
            wheel_d = 1'b1;
            cnt_d   = cnt_q - 32'd1;
          end
        end

        S_LOW: begin
          run_d = 1'b1;
          if (cnt_q == 32'd0) begin
            if (tooth_num < last_tooth) begin
              tooth_d = tooth_num + 8'd1;
              wheel_d = 1'b1;
              cnt_d   = s_high_m1;
              state_d = S_HIGH;
            end else begin
              // The gap is M whole pitches, counted one pitch at a time.
              miss_d  = m_s_q;
              cnt_d   = s_per_m1;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end

        S_GAP: begin
          run_d = 1'b1;
          if (cnt_q == 32'd0) begin
            if (miss_q <= 8'd1) begin
              // Revolution boundary: the only load point while running.
              if (in_valid) begin
                p_s_d   = tooth_period;
                n_s_d   = trigger_tooth_cnt;
                m_s_d   = trigger_teeth_missing;
                tooth_d = 8'd0;
                rev_d   = 1'b1;
                wheel_d = 1'b1;
                cnt_d   = in_high_m1;
                state_d = S_HIGH;
              end else begin
                run_d   = 1'b0;
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              miss_d = miss_q - 8'd1;
              cnt_d  = s_per_m1;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_wheel_gen.sv
`timescale 1ns/1ps
module tb_trig_wheel_gen;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] tooth_period;
  logic [7:0]  n_in;
  logic [7:0]  m_in;
  logic        wheel_out;
  logic [7:0]  tooth_num;
  logic        rev_pulse;
  logic        running;
  logic        cfg_err;

  always #5 clk = ~clk;

  trig_wheel_gen dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .enable                (enable),
    .tooth_period          (tooth_period),
    .trigger_tooth_cnt     (n_in),
    .trigger_teeth_missing (m_in),
    .wheel_out             (wheel_out),
    .tooth_num             (tooth_num),
    .rev_pulse             (rev_pulse),
    .running               (running),
    .cfg_err               (cfg_err)
  );

  // ---------------- scoreboard ----------------
  // Event record for each wheel_out rising edge:
  //   {tooth_num[7:0], rev_pulse, interval since previous rise[15:0], previous high width[7:0]}
  // interval and width are 0 on the first tooth after the generator was idle.
  localparam int W = 33;
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int tooth, input int rev, input int intv, input int width);
    exp_q.push_back({8'(tooth), 1'(rev), 16'(intv), 8'(width)});
  endtask

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           last_rise = 0;
  int           hi_cnt = 0;
  int           last_hi = 0;
  logic         prev_w = 1'b0;
  logic         prev_run = 1'b0;
  logic [W-1:0] mon_act;

  always @(negedge clk) begin
    cyc++;
    if (wheel_out && !prev_w) begin
      mon_act = {tooth_num, rev_pulse,
                 prev_run ? 16'(cyc - last_rise) : 16'd0,
                 prev_run ? 8'(last_hi) : 8'd0};
      last_rise = cyc;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_edge: got %h expected no edge", mon_act);
      end else begin
        check("tooth_edge", mon_act, exp_q.pop_front());
      end
    end
    if (wheel_out) hi_cnt++;
    else begin
      if (prev_w) last_hi = hi_cnt;
      hi_cnt = 0;
    end
    prev_w   = wheel_out;
    prev_run = running;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d events outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stop_gen();
    tick(1);
    enable = 1'b0;
    tick(2);
  endtask

  task automatic push_rev_n12(input int p, input int first_int, input int first_w);
    // tooth 0 then teeth 1..10 of an N=12, M=1 wheel at pitch p
    push(0, 1, first_int, first_w);
    for (int t = 1; t <= 10; t++) push(t, 0, p, p / 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    tooth_period = 32'd10;
    n_in         = 8'd12;
    m_in         = 8'd1;
    #23 reset_n  = 1'b1;
    tick(1);

    // reset state
    check("rst_wheel", wheel_out, 0);
    check("rst_tooth", tooth_num, 0);
    check("rst_rev",   rev_pulse, 0);
    check("rst_run",   running,   0);
    check("rst_err",   cfg_err,   0);

    // 12-1 wheel, P=10: two full revolutions plus the next tooth 0
    push_rev_n12(10, 0, 0);
    push_rev_n12(10, 20, 5);
    push(0, 1, 20, 5);
    enable = 1'b1;
    drain(400);
    stop_gen();

    // 36-2 wheel, P=7: H=3, L=4, gap edge-to-edge 21
    tooth_period = 32'd7;
    n_in = 8'd36;
    m_in = 8'd2;
    push(0, 1, 0, 0);
    for (int t = 1; t <= 33; t++) push(t, 0, 7, 3);
    push(0, 1, 21, 3);
    push(1, 0, 7, 3);
    enable = 1'b1;
    drain(600);
    stop_gen();

    // P changes 10 -> 20 during tooth 5; takes effect at next tooth 0
    tooth_period = 32'd10;
    n_in = 8'd12;
    m_in = 8'd1;
    push_rev_n12(10, 0, 0);
    push(0, 1, 20, 5);
    for (int t = 1; t <= 10; t++) push(t, 0, 20, 10);
    push(0, 1, 40, 10);
    enable = 1'b1;
    tick(56);
    tooth_period = 32'd20;
    drain(600);
    stop_gen();
    tooth_period = 32'd10;

    // invalid configuration
    m_in = 8'd0;
    enable = 1'b1;
    tick(2);
    check("m0_err",   cfg_err,   1);
    check("m0_wheel", wheel_out, 0);
    check("m0_run",   running,   0);
    m_in = 8'd12;
    tick(2);
    check("m12_err",   cfg_err,   1);
    check("m12_wheel", wheel_out, 0);
    push(0, 1, 0, 0);
    push(1, 0, 10, 5);
    m_in = 8'd1;
    tick(1);
    check("fix_wheel", wheel_out, 1);
    check("fix_rev",   rev_pulse, 1);
    check("fix_err",   cfg_err,   0);
    drain(100);
    stop_gen();
    check("dis_err", cfg_err, 0);

    // drop enable in the HIGH phase of tooth 3
    push(0, 1, 0, 0);
    for (int t = 1; t <= 3; t++) push(t, 0, 10, 5);
    enable = 1'b1;
    tick(33);
    enable = 1'b0;
    tick(1);
    check("midhigh_wheel", wheel_out, 0);
    check("midhigh_run",   running,   0);
    check("midhigh_rev",   rev_pulse, 0);
    check("midhigh_tooth", tooth_num, 3);
    drain(5);
    push(0, 1, 0, 0);
    push(1, 0, 10, 5);
    enable = 1'b1;
    tick(1);
    check("reen_tooth", tooth_num, 0);
    check("reen_rev",   rev_pulse, 1);
    drain(50);
    stop_gen();

    // drop enable exactly in the revolution-boundary cycle
    push_rev_n12(10, 0, 0);
    enable = 1'b1;
    tick(120);
    enable = 1'b0;
    tick(1);
    check("bnd_wheel", wheel_out, 0);
    check("bnd_rev",   rev_pulse, 0);
    check("bnd_run",   running,   0);
    check("bnd_tooth", tooth_num, 10);
    drain(5);
    tick(3);
    check("bnd_idle_wheel", wheel_out, 0);
    push(0, 1, 0, 0);
    enable = 1'b1;
    tick(1);
    check("bnd_reen_rev", rev_pulse, 1);
    drain(20);
    stop_gen();

    // asynchronous reset in the middle of the gap
    push_rev_n12(10, 0, 0);
    enable = 1'b1;
    tick(115);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wheel", wheel_out, 0);
    check("arst_tooth", tooth_num, 0);
    check("arst_rev",   rev_pulse, 0);
    check("arst_run",   running,   0);
    check("arst_err",   cfg_err,   0);
    drain(5);
    push(0, 1, 0, 0);
    push(1, 0, 10, 5);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    drain(60);
    stop_gen();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
